// File: rtl/gate_sweep_ctrl_pkg.sv
// Shared definitions for the gate sweep sequencer: reference function codes and FSM states.
// Pure declarations, no logic.
package gate_sweep_ctrl_pkg;

   localparam int FUNC_NAND = 0;
   localparam int FUNC_NOR  = 1;
   localparam int FUNC_AND  = 2;
   localparam int FUNC_OR   = 3;
   localparam int FUNC_XOR  = 4;
   localparam int FUNC_XNOR = 5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } sweep_state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Golden gate: combinational (vec, FUNC) -> expected output; zero latency.
// No flow control; also usable as a reference in benches.
module gate_ref_model
   import gate_sweep_ctrl_pkg::*;
#(
   parameter int N_IN = 2,
   parameter int FUNC = FUNC_NAND
) (
   input  logic [N_IN-1:0] vec,
   output logic            exp_y
);

   always_comb begin
      case (FUNC)
         FUNC_NAND: exp_y = ~(&vec);
         FUNC_NOR:  exp_y = ~(|vec);
         FUNC_AND:  exp_y = &vec;
         FUNC_OR:   exp_y = |vec;
         FUNC_XOR:  exp_y = ^vec;
         FUNC_XNOR: exp_y = ~(^vec);
         default:   exp_y = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive input sweep of N_DUT gate variants against a reference; SETTLE+1 cycles per vector.
// No backpressure: start is ignored while busy, abort wins over everything and returns to IDLE.
module gate_sweep_ctrl
   import gate_sweep_ctrl_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int N_DUT  = 3,
   parameter int FUNC   = FUNC_NAND,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic [N_IN-1:0]  vec,
   input  logic [N_DUT-1:0] dut_y,
   output logic             busy,
   output logic             sample_stb,
   output logic             done,
   output logic             pass,
   output logic [N_IN:0]    err_cnt,
   output logic [N_DUT-1:0] fail_mask,
   output logic [N_IN-1:0]  first_fail_vec,
   output logic             first_fail_vld
);

   localparam int            CW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] CNT_END = CW'(SETTLE - 1);
   localparam logic [N_IN:0] ERR_MAX = {1'b1, {N_IN{1'b0}}};

   sweep_state_t     state, state_nxt;
   logic [CW-1:0]    settle_cnt, settle_cnt_nxt;
   logic [N_IN-1:0]  vec_nxt, ffv_nxt;
   logic [N_IN:0]    err_nxt;
   logic [N_DUT-1:0] mask_nxt, mism;
   logic             ffvld_nxt, exp_y;

   gate_ref_model #(.N_IN(N_IN), .FUNC(FUNC)) u_ref (
      .vec   (vec),
      .exp_y (exp_y)
   );

   assign mism = dut_y ^ {N_DUT{exp_y}};
   assign pass = (state == ST_DONE) && (err_cnt == '0);

   always_comb begin
      state_nxt      = state;
      settle_cnt_nxt = settle_cnt;
      vec_nxt        = vec;
      err_nxt        = err_cnt;
      mask_nxt       = fail_mask;
      ffv_nxt        = first_fail_vec;
      ffvld_nxt      = first_fail_vld;
      if (abort) begin
         // Results stay as a partial record of the cancelled sweep.
         state_nxt      = ST_IDLE;
         vec_nxt        = '0;
         settle_cnt_nxt = '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_nxt      = ST_DRIVE;
                  vec_nxt        = '0;
                  settle_cnt_nxt = '0;
                  err_nxt        = '0;
                  mask_nxt       = '0;
                  ffv_nxt        = '0;
                  ffvld_nxt      = 1'b0;
               end
            end
            ST_DRIVE: begin
               if (settle_cnt == CNT_END) begin
                  state_nxt      = ST_SAMPLE;
                  settle_cnt_nxt = '0;
               end else begin
                  settle_cnt_nxt = settle_cnt + CW'(1);
               end
            end
            ST_SAMPLE: begin
               mask_nxt = fail_mask | mism;
               if (|mism) begin
                  if (err_cnt != ERR_MAX) err_nxt = err_cnt + (N_IN+1)'(1);
                  if (!first_fail_vld) begin
                     ffv_nxt   = vec;
                     ffvld_nxt = 1'b1;
                  end
               end
               // All-ones is terminal: the vector never wraps.
               if (&vec) begin
                  state_nxt = ST_DONE;
               end else begin
                  vec_nxt   = vec + N_IN'(1);
                  state_nxt = ST_DRIVE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         settle_cnt     <= '0;
         vec            <= '0;
         err_cnt        <= '0;
         fail_mask      <= '0;
         first_fail_vec <= '0;
         first_fail_vld <= 1'b0;
         busy           <= 1'b0;
         sample_stb     <= 1'b0;
         done           <= 1'b0;
      end else begin
         state          <= state_nxt;
         settle_cnt     <= settle_cnt_nxt;
         vec            <= vec_nxt;
         err_cnt        <= err_nxt;
         fail_mask      <= mask_nxt;
         first_fail_vec <= ffv_nxt;
         first_fail_vld <= ffvld_nxt;
         busy           <= (state_nxt == ST_DRIVE) || (state_nxt == ST_SAMPLE);
         sample_stb     <= (state_nxt == ST_SAMPLE);
         done           <= (state_nxt == ST_DONE);
      end
   end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomized bench for gate_sweep_ctrl: fault-injected NAND variants, scoreboard of
// expected sample vectors and sweep results, checked by an independent monitor.
module tb_gate_sweep_ctrl;

   localparam int N_IN   = 2;
   localparam int N_DUT  = 3;
   localparam int FUNC   = 0;
   localparam int SETTLE = 2;
   localparam int NV     = 1 << N_IN;
   localparam int PER    = SETTLE + 1;

   logic             clk = 1'b0;
   logic             rst, start, abort;
   logic [N_IN-1:0]  vec;
   logic [N_DUT-1:0] dut_y;
   logic             busy, sample_stb, done, pass;
   logic [N_IN:0]    err_cnt;
   logic [N_DUT-1:0] fail_mask;
   logic [N_IN-1:0]  first_fail_vec;
   logic             first_fail_vld;

   always #5 clk = ~clk;

   gate_sweep_ctrl #(.N_IN(N_IN), .N_DUT(N_DUT), .FUNC(FUNC), .SETTLE(SETTLE)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .abort          (abort),
      .vec            (vec),
      .dut_y          (dut_y),
      .busy           (busy),
      .sample_stb     (sample_stb),
      .done           (done),
      .pass           (pass),
      .err_cnt        (err_cnt),
      .fail_mask      (fail_mask),
      .first_fail_vec (first_fail_vec),
      .first_fail_vld (first_fail_vld)
   );

   // Fault modes: 0 correct, 1 AND instead of NAND, 2 stuck-at-1, 3 stuck-at-0, 4 one flipped vector
   int               fault_mode [N_DUT];
   int               flip_vec   [N_DUT];
   logic [N_DUT-1:0] dut_tab    [NV];
   assign dut_y = dut_tab[vec];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int err;
      int mask;
      int ffv;
      bit ffvld;
      bit pass;
      int done_cyc;
   } res_t;

   int   vec_q [$];
   res_t res_q [$];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // NAND is low only when every input is high
   function automatic bit gold(input int v);
      return !(v == NV - 1);
   endfunction

   function automatic bit dut_out(input int d, input int v);
      case (fault_mode[d])
         1:       return !gold(v);
         2:       return 1'b1;
         3:       return 1'b0;
         4:       return gold(v) ^ (v == flip_vec[d]);
         default: return gold(v);
      endcase
   endfunction

   task automatic set_faults();
      for (int v = 0; v < NV; v++)
         for (int d = 0; d < N_DUT; d++)
            dut_tab[v][d] = dut_out(d, v);
   endtask

   // Result of a sweep whose first nsamp vectors were evaluated.
   function automatic res_t model(input int nsamp);
      res_t r;
      r.err = 0; r.mask = 0; r.ffv = 0; r.ffvld = 1'b0; r.done_cyc = 0;
      for (int v = 0; v < nsamp; v++) begin
         int m = 0;
         for (int d = 0; d < N_DUT; d++)
            if (dut_out(d, v) != gold(v)) m |= (1 << d);
         r.mask |= m;
         if (m != 0) begin
            if (!r.ffvld) begin
               r.ffv   = v;
               r.ffvld = 1'b1;
            end
            if (r.err < NV) r.err++;
         end
      end
      r.pass = (r.err == 0);
      return r;
   endfunction

   // Monitor: compares every sample strobe and every completed sweep against the scoreboard.
   initial begin
      bit   done_prev;
      res_t er;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (sample_stb) begin
            check("sample_expected", int'(vec_q.size() > 0), 1);
            if (vec_q.size() > 0) check("sample_vec", int'(vec), vec_q.pop_front());
         end
         if (done && !done_prev) begin
            check("done_expected", int'(res_q.size() > 0), 1);
            if (res_q.size() > 0) begin
               er = res_q.pop_front();
               check("done_cycle", cyc, er.done_cyc);
               check("err_cnt", int'(err_cnt), er.err);
               check("fail_mask", int'(fail_mask), er.mask);
               check("first_fail_vec", int'(first_fail_vec), er.ffv);
               check("first_fail_vld", int'(first_fail_vld), int'(er.ffvld));
               check("pass", int'(pass), int'(er.pass));
               check("busy_at_done", int'(busy), 0);
            end
         end
         done_prev = done;
      end
   end

   task automatic check_all_zero();
      check("rst_vec", int'(vec), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_stb", int'(sample_stb), 0);
      check("rst_done", int'(done), 0);
      check("rst_pass", int'(pass), 0);
      check("rst_err_cnt", int'(err_cnt), 0);
      check("rst_fail_mask", int'(fail_mask), 0);
      check("rst_ffv", int'(first_fail_vec), 0);
      check("rst_ffvld", int'(first_fail_vld), 0);
   endtask

   // kind: 0 plain, 1 extra start while busy, 2 abort at offset d, 3 abort on the last sample
   task automatic run_sweep(input int kind, input int d);
      int   c, n_seen, n_upd;
      res_t r;
      c = cyc;
      if (kind >= 2) begin
         n_seen = (d >= SETTLE + 1) ? (d - SETTLE - 1) / PER + 1 : 0;
         n_upd  = (d >= PER + 1) ? (d - PER - 1) / PER + 1 : 0;
         if (n_seen > NV) n_seen = NV;
         if (n_upd > NV) n_upd = NV;
      end else begin
         n_seen = NV;
         n_upd  = NV;
      end
      for (int k = 0; k < n_seen; k++) vec_q.push_back(k);
      r = model(n_upd);
      r.done_cyc = c + 1 + NV * PER;
      if (kind < 2) res_q.push_back(r);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (kind < 2) begin
         if (kind == 1) begin
            repeat ($urandom_range(1, 8)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         for (int t = 0; t < 100 && res_q.size() > 0; t++) @(negedge clk);
         check("sweep_completed", int'(res_q.size() == 0), 1);
         res_q.delete();
         check("no_leftover_samples", vec_q.size(), 0);
         vec_q.delete();
         @(negedge clk);
         check("done_held", int'(done), 1);
      end else begin
         while (cyc < c + d) @(negedge clk);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         check("abort_busy", int'(busy), 0);
         check("abort_done", int'(done), 0);
         check("abort_vec", int'(vec), 0);
         check("abort_stb", int'(sample_stb), 0);
         check("abort_samples_seen", vec_q.size(), 0);
         vec_q.delete();
         if (kind == 2) begin
            check("abort_err_cnt", int'(err_cnt), r.err);
            check("abort_fail_mask", int'(fail_mask), r.mask);
            check("abort_ffvld", int'(first_fail_vld), int'(r.ffvld));
            check("abort_ffv", int'(first_fail_vec), r.ffv);
         end
         repeat (3) @(negedge clk);
         check("abort_stays_idle", int'(busy | done), 0);
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      for (int d = 0; d < N_DUT; d++) begin
         fault_mode[d] = 0;
         flip_vec[d]   = 0;
      end
      set_faults();
      repeat (3) @(negedge clk);
      check_all_zero();
      rst = 1'b0;
      @(negedge clk);

      run_sweep(0, 0);
      fault_mode[1] = 1;
      set_faults();
      run_sweep(0, 0);
      fault_mode[1] = 0;
      fault_mode[2] = 2;
      set_faults();
      run_sweep(1, 0);
      fault_mode[2] = 0;
      fault_mode[1] = 1;
      set_faults();
      run_sweep(2, 7);
      run_sweep(3, NV * PER);

      for (int it = 0; it < 14; it++) begin
         int kind, d;
         for (int j = 0; j < N_DUT; j++) begin
            fault_mode[j] = $urandom_range(0, 4);
            flip_vec[j]   = $urandom_range(0, NV - 1);
         end
         set_faults();
         kind = $urandom_range(0, 2);
         d = $urandom_range(2, NV * PER - 1);
         if (d % PER == 0) d--;
         run_sweep(kind, d);
      end

      // Asynchronous reset in the middle of DRIVE
      for (int j = 0; j < N_DUT; j++) fault_mode[j] = 0;
      set_faults();
      vec_q.push_back(0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("pre_rst_busy", int'(busy), 1);
      #2 rst = 1'b1;
      #1 check_all_zero();
      vec_q.delete();
      res_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_sweep(0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
